// File: rtl/fib_split.sv
// fib_split: unpacks one marker/data frame into 16-bit Fibonacci values, one bit per clock.
// Revision: 1.0
`default_nettype none

module fib_split (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] in_S,
  input  logic [63:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] out_b,
  output logic        out_valid,
  output logic        done_split,
  output logic [6:0]  fld_cnt,
  output logic        err,
  output logic        ovf
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [63:0] s_q, s_d;
  logic [63:0] data_q, data_d;
  logic [5:0]  idx_q, idx_d;
  logic [15:0] acc_q, acc_d;
  logic [4:0]  len_q, len_d;
  logic [6:0]  cnt_q, cnt_d;
  logic [15:0] out_b_q, out_b_d;
  logic        out_valid_q, out_valid_d;
  logic        done_q, done_d;
  logic [6:0]  fld_cnt_q, fld_cnt_d;
  logic        err_q, err_d;
  logic        ovf_q, ovf_d;

  logic [15:0] acc_upd;
  logic [63:0] s_above;
  logic        last_bit;

  // Marks strictly above the current bit; none left means the frame is finished.
  assign s_above  = (s_q >> idx_q) >> 1;
  assign last_bit = (idx_q == 6'd63) || (s_above == 64'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      s_q         <= '0;
      data_q      <= '0;
      idx_q       <= '0;
      acc_q       <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      out_b_q     <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      fld_cnt_q   <= '0;
      err_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      data_q      <= data_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      out_b_q     <= out_b_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      fld_cnt_q   <= fld_cnt_d;
      err_q       <= err_d;
      ovf_q       <= ovf_d;
    end
  end

  // The done pulse cycle is already IDLE but is not yet ready for a new frame.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid && !done_q) state_d = (in_S == 64'd0) ? ST_DONE : ST_SCAN;
      ST_SCAN: if (last_bit) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    s_d         = s_q;
    data_d      = data_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    out_b_d     = out_b_q;
    out_valid_d = 1'b0;
    done_d      = 1'b0;
    fld_cnt_d   = fld_cnt_q;
    err_d       = err_q;
    ovf_d       = ovf_q;
    acc_upd     = acc_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (done_q) begin
            ovf_d = 1'b1;
          end else begin
            s_d    = in_S;
            data_d = in_data;
            idx_d  = '0;
            acc_d  = '0;
            len_d  = '0;
            cnt_d  = '0;
          end
        end
      end
      ST_SCAN: begin
        if (in_valid) ovf_d = 1'b1;
        if (len_q < 5'd16) begin
          acc_upd[len_q[3:0]] = data_q[idx_q];
          len_d = len_q + 5'd1;
        end else begin
          err_d = 1'b1;
        end
        acc_d = acc_upd;
        if (s_q[idx_q]) begin
          out_b_d     = acc_upd;
          out_valid_d = 1'b1;
          acc_d       = '0;
          len_d       = '0;
          cnt_d       = cnt_q + 7'd1;
        end
        if (!last_bit) idx_d = idx_q + 6'd1;
      end
      ST_DONE: begin
        if (in_valid) ovf_d = 1'b1;
        done_d    = 1'b1;
        fld_cnt_d = cnt_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    in_ready   = (state_q == ST_IDLE) && !done_q;
    out_b      = out_b_q;
    out_valid  = out_valid_q;
    done_split = done_q;
    fld_cnt    = fld_cnt_q;
    err        = err_q;
    ovf        = ovf_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_fib_split.sv
// tb_fib_split: scoreboard bench for fib_split.
// Revision: 1.0
`default_nettype none

module tb_fib_split;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] in_S = '0;
  logic [63:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] out_b;
  logic        out_valid;
  logic        done_split;
  logic [6:0]  fld_cnt;
  logic        err;
  logic        ovf;

  typedef struct {
    logic [15:0] val;
    int          edge_n;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   exp_done_edge = 0;
  int   exp_cnt = 0;
  logic exp_err = 1'b0;
  logic exp_ovf = 1'b0;

  fib_split dut (
    .clk       (clk),
    .rst       (rst),
    .in_S      (in_S),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_b     (out_b),
    .out_valid (out_valid),
    .done_split(done_split),
    .fld_cnt   (fld_cnt),
    .err       (err),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  // Reference split: walk the marks, collect each field's low 16 bits and its output edge.
  task automatic send_frame(input logic [63:0] s, input logic [63:0] d);
    int start = 0;
    int last  = -1;
    exp_cnt = 0;
    for (int p = 0; p < 64; p++) begin
      if (s[p]) begin
        logic [15:0] v = '0;
        for (int j = 0; j < 16 && start + j <= p; j++) v[j] = d[start + j];
        if (p - start + 1 > 16) exp_err = 1'b1;
        sb.push_back('{v, p + 1});
        exp_cnt++;
        start = p + 1;
        last  = p;
      end
    end
    exp_done_edge = (last < 0) ? 1 : last + 2;
    in_S     = s;
    in_data  = d;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain(input string tag, input int ovf_edge);
    bit seen = 0;
    for (int k = 1; k <= 100; k++) begin
      if (k == ovf_edge) begin
        in_S     = 64'hFFFF;
        in_data  = '1;
        in_valid = 1'b1;
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
      if (k == ovf_edge) exp_ovf = 1'b1;
      vectors++;
      if (in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL %s in_ready_busy E%0d: got %b want 0", tag, k, in_ready);
      end
      if (out_valid === 1'b1) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL %s spurious_out_valid E%0d: got out_b=%h want none", tag, k, out_b);
        end else begin
          exp_t e = sb.pop_front();
          if (out_b !== e.val || k != e.edge_n) begin
            miscompares++;
            $display("FAIL %s out_b: got %h at E%0d want %h at E%0d", tag, out_b, k, e.val, e.edge_n);
          end
        end
      end
      if (done_split === 1'b1) begin
        seen = 1;
        vectors++;
        if (k != exp_done_edge || fld_cnt !== exp_cnt[6:0] || err !== exp_err ||
            ovf !== exp_ovf || sb.size() != 0) begin
          miscompares++;
          $display("FAIL %s done: got E%0d cnt=%0d err=%b ovf=%b left=%0d want E%0d cnt=%0d err=%b ovf=%b left=0",
                   tag, k, fld_cnt, err, ovf, sb.size(), exp_done_edge, exp_cnt, exp_err, exp_ovf);
        end
        break;
      end
    end
    if (!seen) begin
      miscompares++;
      $display("FAIL %s timeout: got no done_split want done at E%0d", tag, exp_done_edge);
      sb.delete();
    end
    @(posedge clk);
    #1;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || done_split !== 1'b0) begin
      miscompares++;
      $display("FAIL %s idle_after: got rdy=%b ov=%b done=%b want 1 0 0", tag, in_ready, out_valid, done_split);
    end
  endtask

  task automatic test_reset();
    vectors++;
    if (in_ready !== 1'b1 || out_b !== 16'h0 || out_valid !== 1'b0 || done_split !== 1'b0 ||
        fld_cnt !== 7'h0 || err !== 1'b0 || ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: got rdy=%b b=%h ov=%b done=%b cnt=%0d err=%b ovf=%b want 1 0 0 0 0 0 0",
               in_ready, out_b, out_valid, done_split, fld_cnt, err, ovf);
    end
  endtask

  task automatic test_two_values();
    send_frame(64'h14, 64'h1D);
    drain("two_values", -1);
  endtask

  task automatic test_full_width();
    send_frame(64'h8000, 64'hFFFF);
    drain("full_width", -1);
  endtask

  task automatic test_empty();
    send_frame(64'h0, 64'hDEAD_BEEF);
    drain("empty", -1);
  endtask

  task automatic test_overlong();
    send_frame(64'h1 << 20, 64'h1F_FFFF);
    drain("overlong", -1);
    send_frame(64'h14, 64'h1D);
    drain("after_overlong", -1);
    vectors++;
    if (err !== 1'b1) begin
      miscompares++;
      $display("FAIL err_sticky: got %b want 1", err);
    end
  endtask

  task automatic test_overrun();
    send_frame(64'h14, 64'h1D);
    drain("overrun", 3);
  endtask

  task automatic test_reset_mid_scan();
    send_frame(64'h14, 64'h1D);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    exp_err = 1'b0;
    exp_ovf = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      vectors++;
      if (in_ready !== 1'b1 || out_b !== 16'h0 || out_valid !== 1'b0 || done_split !== 1'b0 ||
          fld_cnt !== 7'h0 || err !== 1'b0 || ovf !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_mid_scan c%0d: got rdy=%b b=%h ov=%b done=%b cnt=%0d err=%b ovf=%b want 1 0 0 0 0 0 0",
                 k, in_ready, out_b, out_valid, done_split, fld_cnt, err, ovf);
      end
      @(posedge clk);
    end
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    send_frame(64'h14, 64'h1D);
    drain("after_reset", -1);
  endtask

  task automatic test_back_to_back();
    logic [63:0] s;
    logic [63:0] d;
    for (int n = 0; n < 5; n++) begin
      s = {$urandom(), $urandom()};
      d = {$urandom(), $urandom()};
      if (n == 0) s = 64'h8000_0000_0000_0000;
      if (n == 1) s = s & 64'h0000_0000_0000_0F0F;
      send_frame(s, d);
      drain("back_to_back", -1);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    test_two_values();
    test_full_width();
    test_empty();
    test_overlong();
    test_overrun();
    test_reset_mid_scan();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fib_split.md
# fib_split

Receive-side unpacker for Fibonacci-coded transfers. Consumes one packed frame (64-bit marker word plus 64-bit data word, as emitted by the packing stage's `out_S`/`out_data` with its `done_comb` strobe) and splits it back into individual 16-bit values, one bit per clock. Recovered values go to the downstream Fibonacci decoder, one strobe per value. A frame-complete strobe follows the last value.

## Interface
- No parameters. Frame width is fixed at 64 and value width at 16.
- `clk` input, 1 bit: system clock, rising edge.
- `rst` input, 1 bit: asynchronous, active-low reset.
- `in_S` input, 64 bits: marker word. Bit p = 1 marks the MSB of a field.
- `in_data` input, 64 bits: packed field bits.
- `in_valid` input, 1 bit: one-cycle frame strobe. Driven by the packer's `done_comb`.
- `in_ready` output, 1 bit: high while in IDLE.
- `out_b` output, 16 bits: the recovered value. Holds until the next field is emitted.
- `out_valid` output, 1 bit: one-cycle pulse per recovered value.
- `done_split` output, 1 bit: one-cycle pulse at frame end.
- `fld_cnt` output, 7 bits: number of fields in the last frame. Valid while `done_split` is high and held afterwards.
- `err` output, 1 bit: sticky. Set when any field is longer than 16 bits.
- `ovf` output, 1 bit: sticky. Set when `in_valid` arrives while not in IDLE.

## Operation
- Frame format:
  - Fields are contiguous from bit 0 upward; field 0 is the lowest.
  - Field k spans from the bit after the previous mark up to and including its own mark.
  - Value bit j of field k equals `in_data[start_k + j]`.
  - Data bits above the highest mark are ignored.
- State IDLE:
  - `in_ready` = 1.
  - On `in_valid`: latch `in_S` and `in_data`; clear index i, accumulator acc and length len; clear the field counter.
  - If `in_S == 0`, go to DONE. Otherwise go to SCAN.
- State SCAN, one bit i per cycle:
  - If len < 16: `acc[len] <= in_data[i]`. Otherwise set `err` and drop the bit.
  - len increments, saturating at 16.
  - If `S[i] == 1`: `out_b <=` the updated acc (including the current bit), `out_valid <= 1`, acc and len cleared, field counter incremented.
  - Termination: if i == 63, or every S bit above i is 0, go to DONE. Otherwise i increments.
- State DONE: `done_split <= 1`, `fld_cnt <=` field counter, return to IDLE.
- `in_valid` in SCAN or DONE is ignored; it sets `ovf`. The frame in progress is unaffected.
- `err` and `ovf` are cleared only by reset.

## Timing
- Reset values: every output is 0, except `in_ready` = 1. State is IDLE; internal registers are 0.
- Edge numbering: E0 is the edge that samples `in_valid`. Edge E(i+1) processes bit i.
- A field whose mark is at bit p produces `out_valid` during the cycle after E(p+1).
- `done_split` is high during the cycle after E(L+2), where L is the highest mark. That is exactly one cycle after the final `out_valid`.
- Empty frame: `done_split` after E1, no `out_valid`, `fld_cnt` = 0.
- `in_ready` is low from the cycle after E0 through the `done_split` cycle. A new frame may be strobed in the cycle after `done_split`.
- Worst-case latency is 65 edges, for a mark at bit 63.
- Reset asserted mid-frame: the frame is aborted immediately, no further `out_valid` or `done_split` is produced, and all outputs return to their reset values.

## Test plan
- Two values, 5 and 3: `in_S`=0x14, `in_data`=0x1D.
  - `out_b`=5 after E3.
  - `out_b`=3 after E5.
  - `done_split` after E6, `fld_cnt`=2, `err`=0.
- Single full-width value: `in_S`=0x8000, `in_data`=0xFFFF.
  - One `out_valid` after E16 with `out_b`=0xFFFF.
  - `done_split` after E17, `fld_cnt`=1.
- Empty frame: `in_S`=0.
  - `done_split` after E1, `fld_cnt`=0, no `out_valid`.
- Over-long field: `in_S`=1<<20, `in_data`=0x1FFFFF.
  - `out_b`=0xFFFF after E21.
  - `err`=1 and remains 1 through the next clean frame.
- Overrun: strobe `in_valid` at E3 during the first scenario.
  - Outputs identical to the first scenario.
  - `ovf`=1; `in_ready` stays 0 until IDLE.
- Reset mid-scan: drop `rst` after E2 of the first scenario.
  - No `out_valid` and no `done_split`; all outputs 0.
  - A frame strobed after reset release decodes normally.
